// File: rtl/ibex_retire_trace_buffer.sv
// ibex_retire_trace_buffer: captures retiring instructions into a small FIFO
// and streams them, in order, to a trace consumer over valid/ready.
// Latency: a record pushed in cycle N is at the head in cycle N+1; occupancy,
//          overflow and drop count are registered and reflect cycle N in N+1.
// Backpressure: when full and not popping, the retire is dropped; the
//          sequence number still advances, so the consumer sees a gap.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   clear_i                 synchronous clear (wins over push, pop and retire)
//   instr_done_i, pc_i, instr_rdata_i, rf_we_i, rf_waddr_i, rf_wdata_i
//                           retire interface from writeback
//   trace_valid_o/ready_i   head-record stream handshake
//   trace_seq_o .. trace_wdata_o   head record fields, zero when not valid
//   occupancy_o, overflow_o, drop_cnt_o   status
module ibex_retire_trace_buffer #(
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     instr_done_i,
  input  logic [31:0]              pc_i,
  input  logic [31:0]              instr_rdata_i,
  input  logic                     rf_we_i,
  input  logic [4:0]               rf_waddr_i,
  input  logic [31:0]              rf_wdata_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [31:0]              trace_seq_o,
  output logic [31:0]              trace_pc_o,
  output logic [31:0]              trace_instr_o,
  output logic                     trace_we_o,
  output logic [4:0]               trace_waddr_o,
  output logic [31:0]              trace_wdata_o,
  output logic [$clog2(Depth):0]   occupancy_o,
  output logic                     overflow_o,
  output logic [15:0]              drop_cnt_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] LP_FULL = (AW + 1)'(Depth);

  typedef struct packed {
    logic [31:0] seq;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rec_t;

  // Storage is not reset: the data outputs are gated by valid.
  rec_t            r_mem [Depth];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_occ;
  logic [31:0]     r_seq;
  logic            r_overflow;
  logic [15:0]     r_drop_cnt;

  logic            w_valid;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic            w_we;
  rec_t            w_rec;
  rec_t            w_head;

  // Valid comes only from registered occupancy, so there is no combinational
  // path from instr_done_i to trace_valid_o.
  assign w_valid = (r_occ != '0);
  assign w_full  = (r_occ == LP_FULL);

  // Pop frees a slot in the same cycle, so full + pop still accepts a push.
  assign w_pop  = w_valid & trace_ready_i & ~clear_i;
  assign w_push = instr_done_i & ~clear_i & (~w_full | w_pop);
  assign w_drop = instr_done_i & ~clear_i & w_full & ~w_pop;

  // Writes to x0 are architecturally invisible; report them as no write.
  assign w_we = rf_we_i & (rf_waddr_i != 5'd0);

  always_comb begin
    w_rec       = '0;
    w_rec.seq   = r_seq;
    w_rec.pc    = pc_i;
    w_rec.instr = instr_rdata_i;
    w_rec.we    = w_we;
    w_rec.waddr = rf_waddr_i;
    w_rec.wdata = w_we ? rf_wdata_i : 32'd0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_occ      <= '0;
      r_seq      <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clear_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_occ      <= '0;
      r_seq      <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      // Every retire consumes a sequence number, dropped or not.
      if (instr_done_i) begin
        r_seq <= r_seq + 32'd1;
      end
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_occ <= r_occ + (AW + 1)'(1);
      end else if (w_pop && !w_push) begin
        r_occ <= r_occ - (AW + 1)'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) begin
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_rec;
    end
  end

  assign w_head = r_mem[r_rptr];

  assign trace_valid_o = w_valid;
  assign trace_seq_o   = w_valid ? w_head.seq   : 32'd0;
  assign trace_pc_o    = w_valid ? w_head.pc    : 32'd0;
  assign trace_instr_o = w_valid ? w_head.instr : 32'd0;
  assign trace_we_o    = w_valid ? w_head.we    : 1'b0;
  assign trace_waddr_o = w_valid ? w_head.waddr : 5'd0;
  assign trace_wdata_o = w_valid ? w_head.wdata : 32'd0;

  assign occupancy_o = r_occ;
  assign overflow_o  = r_overflow;
  assign drop_cnt_o  = r_drop_cnt;

endmodule

// File: doc/ibex_retire_trace_buffer.md
# ibex_retire_trace_buffer

Consumer of the writeback stage's retire interface. Each cycle `instr_done_i` is high, it captures the retiring instruction's PC, instruction word and register-file write into a small FIFO. It presents the buffered records, in order, on a valid/ready stream to the contract-generation testbench. Each record carries a retire sequence number, so losses caused by back-pressure are visible to the consumer as gaps.

## Interface
- `Depth`, default 4: number of FIFO entries; must be a power of two, ≥2.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `clear_i` in 1: synchronous clear of FIFO, counters and overflow flag.
- `instr_done_i` in 1: an instruction retires this cycle.
- `pc_i` in 32: PC of the retiring instruction.
- `instr_rdata_i` in 32: instruction word of the retiring instruction.
- `rf_we_i` in 1: the retiring instruction writes the register file this cycle.
- `rf_waddr_i` in 5: destination register.
- `rf_wdata_i` in 32: write data.
- `trace_valid_o` out 1: a record is available at the FIFO head.
- `trace_ready_i` in 1: the consumer accepts the head record.
- `trace_seq_o` out 32: retire sequence number of the head record.
- `trace_pc_o` out 32: PC of the head record.
- `trace_instr_o` out 32: instruction word of the head record.
- `trace_we_o` out 1: register write enable of the head record.
- `trace_waddr_o` out 5: destination register of the head record.
- `trace_wdata_o` out 32: write data of the head record.
- `occupancy_o` out $clog2(Depth)+1: number of valid entries.
- `overflow_o` out 1: sticky flag; set when a record has been dropped.
- `drop_cnt_o` out 16: count of dropped records, saturating.

## Operation
- **Sequence counter.**
  - 32-bit `seq_q` increments by 1, wrapping, on every `instr_done_i`, including dropped records.
  - A record stores the `seq_q` value from before the increment.
  - The first retire after reset or clear gets seq 0.
- **Record capture.**
  - Fields stored: {seq, pc, instr, we, waddr, wdata}.
  - `we` is stored as `rf_we_i & (rf_waddr_i != 0)`. x0 writes are reported as no write.
  - `wdata` is stored as 0 when the stored `we` is 0.
- **Pop.** Occurs when `trace_valid_o & trace_ready_i`.
- **Push.** Occurs when `instr_done_i & ~clear_i & (~full | pop)`. Full plus a simultaneous pop still accepts the push; occupancy is unchanged.
- **Drop.** Occurs when `instr_done_i & ~clear_i & full & ~pop`.
  - The record is discarded.
  - `overflow_o` is set.
  - `drop_cnt_o` increments, saturating at 0xFFFF.
- **Pointers.** Read and write pointers are $clog2(Depth) bits wide and wrap naturally. Full/empty are derived from a separate occupancy counter.
- **Output gating.** When `trace_valid_o` = 0, all `trace_*` data outputs are driven to 0, which keeps contract comparisons deterministic.
- **Stream stability.** While `trace_valid_o` = 1 and `trace_ready_i` = 0, the head record holds stable.
- **Clear.** `clear_i` has priority over all other events. In the same cycle:
  - occupancy, pointers, `seq_q`, `overflow_o` and `drop_cnt_o` are zeroed;
  - any push or pop that cycle is ignored;
  - a retire in that cycle is neither stored nor counted.

## Timing
- **Reset.** Asynchronous, with the same effect as clear. All outputs are 0, including `trace_valid_o`, `occupancy_o`, `overflow_o` and `drop_cnt_o`. Storage contents need no reset because the data outputs are gated.
- **Push latency.** A record pushed in cycle N is visible at the head from cycle N+1 if the FIFO was empty. There is no combinational path from `instr_done_i` to `trace_valid_o`.
- **Pop timing.** A pop in cycle N exposes the next entry in cycle N+1. `trace_valid_o` deasserts in N+1 if that pop emptied the FIFO.
- **Back-to-back.** `instr_done_i` may be high every cycle; with `trace_ready_i` high every cycle, throughput is 1 record per cycle with no drops.
- **Registered outputs.** `occupancy_o`, `overflow_o` and `drop_cnt_o` are register outputs and update in the cycle after the event.
- **Reset mid-stream.** The in-flight head record is lost and `trace_valid_o` falls immediately, since reset is asynchronous.

## Test plan
- **Single retire.** Stimulus: reset, then one retire with pc=0x80, instr=0x00500093, we=1, waddr=1, wdata=5, and `trace_ready_i`=1. Response: next cycle valid=1 with seq 0, pc 0x80, we 1, waddr 1, wdata 5; valid=0 the cycle after.
- **x0 write.** Stimulus: a retire with we=1, waddr=0, wdata=0xDEADBEEF. Response: record shows we=0, wdata=0.
- **Overflow.** Stimulus: Depth=4, `trace_ready_i`=0, 6 back-to-back retires. Response:
  - occupancy=4, overflow=1, drop_cnt=2;
  - after raising ready, seqs 0,1,2,3 emerge in order;
  - a 7th retire then carries seq 6.
- **Full with simultaneous push and pop.** Stimulus: FIFO full, retire with ready=1 in the same cycle. Response: no drop, occupancy stays 4, and the new record appears after the 3 older ones.
- **Clear priority.** Stimulus: `clear_i` and a retire in the same cycle with 2 entries held and overflow set. Response: next cycle valid=0, occupancy=0, overflow=0, drop_cnt=0; the next retire gets seq 0.
- **Async reset mid-stream.** Stimulus: assert `rst_ni`=0 mid-cycle while valid=1. Response: all outputs go to 0 immediately; after release, the first retire gets seq 0.
